// File: rtl/dm_access_unit_if.sv
// dm_access_unit_if: request/response bundle between the core datapath and
// the data-memory access stage.
//   req, we, op, addr, din      : request from the core (master drives)
//   DataOut, busy, done,
//   misalign                    : response from the access unit (slave drives)
interface dm_access_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] DataOut;
    logic        busy;
    logic        done;
    logic        misalign;

    modport master (
        output req, we, op, addr, din,
        input  DataOut, busy, done, misalign
    );

    modport slave (
        input  req, we, op, addr, din,
        output DataOut, busy, done, misalign
    );
endinterface

// File: rtl/dm_access_unit.sv
// dm_access_unit: data-memory stage of the single-cycle MIPS core.
// Owns a word-organised synchronous RAM (2^ADDR_WIDTH x 32) with byte-lane
// writes. Stores complete without stalling; loads stall one cycle via busy
// and return aligned, sign/zero-extended data on DataOut.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dm_access_unit_if.slave (req/we/op/addr/din in;
//              DataOut/busy/done/misalign out)
module dm_access_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    dm_access_unit_if.slave   bus
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t state_q, state_d;

    logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] widx;
    logic                  aligned;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  store_acc, load_acc, mis_acc;
    logic                  busy_c;

    logic [31:0]           rdata_q;
    logic [2:0]            op_q;
    logic [1:0]            lane_q;
    logic [31:0]           dout_q;
    logic                  done_q;
    logic                  mis_q;
    logic [31:0]           fmt;
    logic [15:0]           half_sel;
    logic [7:0]            byte_sel;

    // Upper address bits alias onto the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2]};

    assign widx = bus.addr[ADDR_WIDTH+1:2];

    // Alignment check, lane enables and lane-replicated store data.
    always_comb begin
        aligned = 1'b1;
        be      = 4'b1111;
        wdata   = bus.din;
        case (bus.op)
            3'b001, 3'b010: begin
                aligned = ~bus.addr[0];
                be      = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{bus.din[15:0]}};
            end
            3'b011, 3'b100: begin
                be    = 4'b0001 << bus.addr[1:0];
                wdata = {4{bus.din[7:0]}};
            end
            default: begin
                aligned = (bus.addr[1:0] == 2'b00);
            end
        endcase
    end

    // Requests are only taken in IDLE; anything seen in RESP is the stalled
    // load being re-presented.
    assign store_acc = !rst && (state_q == IDLE) && bus.req &&  bus.we && aligned;
    assign load_acc  = !rst && (state_q == IDLE) && bus.req && !bus.we && aligned;
    assign mis_acc   = !rst && (state_q == IDLE) && bus.req && !aligned;

    // RAM: not affected by reset.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[widx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
        if (load_acc) begin
            rdata_q <= mem[widx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            dout_q  <= '0;
            op_q    <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= store_acc;
            mis_q   <= mis_acc;
            if (load_acc) begin
                op_q   <= bus.op;
                lane_q <= bus.addr[1:0];
            end
            if (state_q == RESP) begin
                dout_q <= fmt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_c = load_acc;
                if (load_acc) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load formatting from the RAM output word.
    always_comb begin
        half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (lane_q)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        case (op_q)
            3'b001:  fmt = {{16{half_sel[15]}}, half_sel};
            3'b010:  fmt = {16'h0000, half_sel};
            3'b011:  fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  fmt = {24'h000000, byte_sel};
            default: fmt = rdata_q;
        endcase
    end

    // During RESP the formatted word bypasses the register so the core can
    // sample it at the end of that cycle.
    assign bus.DataOut  = (state_q == RESP && !rst) ? fmt : dout_q;
    assign bus.busy     = busy_c;
    assign bus.done     = !rst && (done_q || state_q == RESP);
    assign bus.misalign = !rst && mis_q;
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: directed scoreboard bench for dm_access_unit.
module tb_dm_access_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dm_access_unit_if bus ();

    dm_access_unit #(.ADDR_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        mis;
        logic        load;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [2:0] OP_W = 3'b000, OP_H = 3'b001, OP_HU = 3'b010,
                           OP_B = 3'b011, OP_BU = 3'b100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every done/misalign pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.done || bus.misalign)) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_response: got done=%0b misalign=%0b expected none",
                         bus.done, bus.misalign);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.misalign !== e.mis || bus.done !== !e.mis || (e.mis && bus.busy !== 1'b0))
                    $display("FAIL response_kind: got done=%0b misalign=%0b busy=%0b expected misalign=%0b",
                             bus.done, bus.misalign, bus.busy, e.mis);
                else if (e.load && bus.DataOut !== e.data)
                    $display("FAIL load_data: got 0x%08h expected 0x%08h", bus.DataOut, e.data);
                else
                    passes++;
            end
        end
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 ready for the next
    // request. For loads req is kept high through RESP, which must be ignored.
    task automatic do_op(input logic w, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_mis, input logic [31:0] exp_data);
        exp_t e;
        bus.req  = 1'b1;
        bus.we   = w;
        bus.op   = o;
        bus.addr = a;
        bus.din  = d;
        e.mis  = exp_mis;
        e.load = !w && !exp_mis;
        e.data = exp_data;
        q.push_back(e);
        @(negedge clk);
        check($sformatf("busy@%08h", a), {31'd0, bus.busy}, {31'd0, (!w && !exp_mis)});
        @(posedge clk); #1;
        if (!w && !exp_mis) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic hold_check(input string name, input logic [31:0] exp);
        bus.req = 1'b0;
        @(negedge clk);
        check(name, bus.DataOut, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.op   = OP_W;
        bus.addr = 32'h10;
        bus.din  = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", {31'd0, bus.busy}, 32'd0);
            check("rst_done", {31'd0, bus.done}, 32'd0);
            check("rst_dataout", bus.DataOut, 32'd0);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        bus.req = 1'b0;
        @(negedge clk);
        check("post_rst_done", {31'd0, bus.done}, 32'd0);
        check("post_rst_dataout", bus.DataOut, 32'd0);
        @(posedge clk); #1;

        // Word store then immediate load of the same word.
        do_op(1, OP_W,  32'h10, 32'h89ABCDEF, 0, 0);
        do_op(0, OP_W,  32'h10, 0, 0, 32'h89ABCDEF);
        hold_check("hold_lw", 32'h89ABCDEF);
        hold_check("hold_lw2", 32'h89ABCDEF);

        // Sub-word loads.
        do_op(0, OP_B,  32'h11, 0, 0, 32'hFFFFFFCD);
        do_op(0, OP_BU, 32'h13, 0, 0, 32'h00000089);
        do_op(0, OP_H,  32'h12, 0, 0, 32'hFFFF89AB);
        do_op(0, OP_HU, 32'h10, 0, 0, 32'h0000CDEF);
        hold_check("hold_lhu", 32'h0000CDEF);

        // Sub-word stores (upper din bits must be ignored); neighbour word intact.
        do_op(1, OP_W,  32'h14, 32'h11111111, 0, 0);
        do_op(1, OP_B,  32'h12, 32'hFFFFFF5A, 0, 0);
        do_op(1, OP_H,  32'h10, 32'hABCD1234, 0, 0);
        do_op(0, OP_W,  32'h10, 0, 0, 32'h895A1234);
        do_op(0, OP_W,  32'h14, 0, 0, 32'h11111111);

        // Misaligned accesses; op 101/111 behave as word.
        do_op(1, OP_W,  32'h20, 32'hCAFEF00D, 0, 0);
        do_op(0, OP_W,  32'h20, 0, 0, 32'hCAFEF00D);
        do_op(0, OP_W,  32'h22, 0, 1, 0);
        do_op(0, OP_H,  32'h21, 0, 1, 0);
        do_op(1, OP_W,  32'h13, 32'hDEADBEEF, 1, 0);
        do_op(0, 3'b111, 32'h22, 0, 1, 0);
        hold_check("hold_after_misalign", 32'hCAFEF00D);
        do_op(0, OP_W,  32'h10, 0, 0, 32'h895A1234);
        do_op(0, OP_B,  32'h23, 0, 0, 32'hFFFFFFCA);
        do_op(0, 3'b101, 32'h20, 0, 0, 32'hCAFEF00D);

        // Reset during RESP discards the load.
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.op   = OP_W;
        bus.addr = 32'h10;
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        rst     = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dataout", bus.DataOut, 32'd0);
        check("midrst_done_after", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;

        // Address aliasing beyond the RAM size.
        do_op(1, OP_W,  32'h1000_0010, 32'h5555AAAA, 0, 0);
        do_op(0, OP_W,  32'h10, 0, 0, 32'h5555AAAA);
        do_op(0, OP_HU, 32'h0000_1012, 0, 0, 32'h00005555);

        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Data-memory access stage of the single-cycle MIPS core: accepts load/store requests from the execute datapath (address = ALU result, store data = register-file read port 2), owns a word-organised synchronous data RAM with byte-lane writes, and returns aligned, sign/zero-extended load data on `DataOut`, the DM source of the register write-back select. A synchronous RAM read costs one extra cycle, so loads stall the core for one cycle via `busy`; stores complete without stalling.

## Interface
- `ADDR_WIDTH`, 10, word-address width; RAM holds 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  memory instruction present this cycle.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `op`  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 treated as word.
- `addr`  in  32  byte address.
- `din`  in  32  store data; sub-word stores use low bits.
- `DataOut`  out  32  formatted load data, registered.
- `busy`  out  1  combinational stall request to PC/pipeline.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  one-cycle address-error pulse.

## Operation
- Byte order little-endian: lane k = bits [8k+7:8k], lane = addr[1:0]; word index = addr[ADDR_WIDTH+1:2]; upper addr bits ignored (aliasing wraps).
- Alignment: word requires addr[1:0]=00, half requires addr[0]=0, byte always aligned. Misaligned request: no RAM write, no read, `DataOut` unchanged, `misalign` pulses next cycle, `done` stays 0, `busy` stays 0.
- FSM states IDLE, RESP.
  - IDLE, no `req`: stay.
  - IDLE, `req`&`we`, aligned: write enabled lanes at edge (word: all 4; half: lanes 0–1 or 2–3 with din[15:0]; byte: single lane with din[7:0]); stay IDLE; `done`=1 next cycle.
  - IDLE, `req`&!`we`, aligned: `busy`=1 this cycle; RAM read issued; latch op and addr[1:0]; go RESP.
  - RESP: select lane(s) from RAM output, extend per latched op (signed: replicate bit 15/7; unsigned: zero), load `DataOut` at end of RESP; `done`=1 during RESP... see Timing; `busy`=0; any `req` present in RESP is the same instruction and is ignored; return IDLE.
- `busy` = (state==IDLE) & `req` & !`we` & aligned. Never asserted in RESP.
- RAM contents not cleared by `rst`; initial contents undefined (bench preloads or writes first).

## Timing
- Reset values: state IDLE, `DataOut`=0, `done`=0, `misalign`=0; `busy`=0 while `rst` high regardless of inputs.
- Load accepted cycle N: `busy`=1 in N; state RESP in N+1 with `done`=1 and formatted data driven on `DataOut` combinationally-bypassed from RAM output in N+1; `DataOut` register holds that value from N+2 until next load completes. Core samples load data at end of N+1.
- Store accepted cycle N: RAM updated at end of N; `done`=1 in N+1. A load in N+1 to the same word returns the new data.
- Misaligned in N: `misalign`=1 in N+1 only.
- Back-to-back: load/store may be accepted in the cycle after RESP (IDLE again). Store immediately after a load's RESP proceeds normally.
- `rst` during RESP: next state IDLE, `done`/`misalign` 0, `DataOut`=0, pending load discarded.
- Simultaneous `req` and `rst`: reset wins, no RAM write.

## Test plan
- Reset: drive `req`=1,`we`=0 with `rst`=1 for 2 cycles -> `busy`=0, `DataOut`=0, `done`=0, state IDLE after release.
- Word store/load: sw 0x89ABCDEF to 0x10, then lw 0x10 -> `busy` 1 cycle, `done` in RESP, `DataOut`=0x89ABCDEF held afterwards.
- Sub-word loads on word 0x89ABCDEF@0x10: lb 0x11 -> 0xFFFFFFCD; lbu 0x13 -> 0x00000089; lh 0x12 -> 0xFFFF89AB; lhu 0x10 -> 0x0000CDEF.
- Sub-word stores: sb 0x5A to 0x12 then sh 0x1234 to 0x10 -> lw 0x10 returns 0x895A1234; other words unchanged.
- Misalign: lw 0x22, lh 0x21, sw 0x13 -> `misalign` pulse next cycle, `busy`=0, no `done`, memory and `DataOut` unchanged; lb 0x23 accepted normally.
- Reset mid-load and aliasing: assert `rst` in RESP -> `DataOut`=0, no `done`; sw to 0x1000_0010 (ADDR_WIDTH=10) then lw 0x10 returns stored value.
